duv_resp_checker: RTL and testbench

Synthesizable response checker on the receiving end of the `duv` 2:1 mux stimulus interface. It samples the same `sel`/`in0`/`in1` stimulus that drives the DUV and delays a reference result by the DUV's pipeline latency. It compares that result against the DUV `out` and reports pass/fail counts through a start/done handshake. It sits beside `u_duv` in the prototype bench and replaces manual `$monitor` inspection with self-checking hardware usable in FPGA prototypes.

---
 rtl/duv_resp_checker.sv | 198 +++++++++++++++++++
 tb/tb_duv_resp_checker.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duv_resp_checker.sv
// Response checker for the duv 2:1 mux: delays sel ? in1 : in0 by LAT cycles and scores it against out.
// Define DUV_CHK_FIRST_FAIL_EN to capture the index and vector of the first mismatch of each run.
module duv_resp_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned NVEC  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic             vld,
    input  logic             sel,
    input  logic             in0,
    input  logic             in1,
    input  logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] ff_idx,
    output logic [2:0]       ff_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NVEC - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             v_q   [LAT];
    logic             v_d   [LAT];
    logic             exp_q [LAT];
    logic             exp_d [LAT];
`ifdef DUV_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] sidx_q [LAT];
    logic [CNT_W-1:0] sidx_d [LAT];
    logic [2:0]       svec_q [LAT];
    logic [2:0]       svec_d [LAT];
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [2:0]       ff_vec_q, ff_vec_d;
`endif

    logic accept;
    logic cmp_vld;
    logic cmp_miss;
    logic pipe_any;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        idx_d    = idx_q;
        accept   = (state_q == S_RUN) && vld;
        cmp_vld  = v_q[LAT-1];
        cmp_miss = cmp_vld && (out != exp_q[LAT-1]);

        v_d[0]   = accept;
        exp_d[0] = sel ? in1 : in0;
        for (int unsigned i = 1; i < LAT; i++) begin
            v_d[i]   = v_q[i-1];
            exp_d[i] = exp_q[i-1];
        end
`ifdef DUV_CHK_FIRST_FAIL_EN
        ff_idx_d  = ff_idx_q;
        ff_vec_d  = ff_vec_q;
        sidx_d[0] = idx_q;
        svec_d[0] = {sel, in0, in1};
        for (int unsigned i = 1; i < LAT; i++) begin
            sidx_d[i] = sidx_q[i-1];
            svec_d[i] = svec_q[i-1];
        end
`endif

        pipe_any = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            pipe_any = pipe_any | v_d[i];
        end

        if (cmp_vld) begin
            if (cmp_miss) begin
                if (fail_q != '1) begin
                    fail_d = fail_q + 1'b1;
                end
                err_d = 1'b1;
`ifdef DUV_CHK_FIRST_FAIL_EN
                if (!err_q) begin
                    ff_idx_d = sidx_q[LAT-1];
                    ff_vec_d = svec_q[LAT-1];
                end
`endif
            end else if (pass_q != '1) begin
                pass_d = pass_q + 1'b1;
            end
        end

        // done is raised from DRAIN and the return to IDLE waits one more cycle,
        // so a start coinciding with done is still ignored
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    pass_d  = '0;
                    fail_d  = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
`ifdef DUV_CHK_FIRST_FAIL_EN
                    ff_idx_d = '0;
                    ff_vec_d = '0;
`endif
                    for (int unsigned i = 0; i < LAT; i++) begin
                        v_d[i] = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (!pipe_any) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            v_q     <= '{default: 1'b0};
            exp_q   <= '{default: 1'b0};
`ifdef DUV_CHK_FIRST_FAIL_EN
            sidx_q   <= '{default: '0};
            svec_q   <= '{default: '0};
            ff_idx_q <= '0;
            ff_vec_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            v_q     <= v_d;
            exp_q   <= exp_d;
`ifdef DUV_CHK_FIRST_FAIL_EN
            sidx_q   <= sidx_d;
            svec_q   <= svec_d;
            ff_idx_q <= ff_idx_d;
            ff_vec_q <= ff_vec_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
`ifdef DUV_CHK_FIRST_FAIL_EN
    assign ff_idx   = ff_idx_q;
    assign ff_vec   = ff_vec_q;
`else
    assign ff_idx   = '0;
    assign ff_vec   = '0;
`endif

endmodule

// File: tb/tb_duv_resp_checker.sv
// Bench for duv_resp_checker: three parameterizations run in lockstep against a
// scoreboard that schedules each accepted vector's expected compare at its due cycle.
`timescale 1ns/1ps
module tb_duv_resp_checker;

    localparam int NI = 3;

    int unsigned lat_k  [NI] = '{1, 3, 2};
    int unsigned nvec_k [NI] = '{8, 8, 3};
    int unsigned max_k  [NI] = '{32'hFFFF, 32'hFFFF, 3};

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    logic start  = 1'b0;
    logic vld    = 1'b0;
    logic sel    = 1'b0;
    logic in0    = 1'b0;
    logic in1    = 1'b0;
    logic cor    [NI];
    logic out_w  [NI];
    logic busy_w [NI];
    logic done_w [NI];
    logic err_w  [NI];
    logic [15:0] pass_w [NI];
    logic [15:0] fail_w [NI];
    logic [15:0] ffi_w  [NI];
    logic [2:0]  ffv_w  [NI];
    logic [1:0]  pass_c, fail_c, ffi_c;

    always #5 clk = ~clk;

    duv_resp_checker #(.LAT(1), .NVEC(8), .CNT_W(16)) u_a (
        .clk(clk), .nreset(nreset), .start(start), .vld(vld), .sel(sel), .in0(in0), .in1(in1),
        .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass_cnt(pass_w[0]),
        .fail_cnt(fail_w[0]), .err(err_w[0]), .ff_idx(ffi_w[0]), .ff_vec(ffv_w[0])
    );

    duv_resp_checker #(.LAT(3), .NVEC(8), .CNT_W(16)) u_b (
        .clk(clk), .nreset(nreset), .start(start), .vld(vld), .sel(sel), .in0(in0), .in1(in1),
        .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass_cnt(pass_w[1]),
        .fail_cnt(fail_w[1]), .err(err_w[1]), .ff_idx(ffi_w[1]), .ff_vec(ffv_w[1])
    );

    duv_resp_checker #(.LAT(2), .NVEC(3), .CNT_W(2)) u_c (
        .clk(clk), .nreset(nreset), .start(start), .vld(vld), .sel(sel), .in0(in0), .in1(in1),
        .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass_cnt(pass_c),
        .fail_cnt(fail_c), .err(err_w[2]), .ff_idx(ffi_c), .ff_vec(ffv_w[2])
    );

    assign pass_w[2] = {14'd0, pass_c};
    assign fail_w[2] = {14'd0, fail_c};
    assign ffi_w[2]  = {14'd0, ffi_c};

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    // reference state per instance
    bit          run_m  [NI];
    bit          dn_m   [NI];
    bit          err_m  [NI];
    int unsigned acc_m  [NI];
    int unsigned last_m [NI];
    int unsigned pass_m [NI];
    int unsigned fail_m [NI];
    int unsigned ffi_m  [NI];
    bit [2:0]    ffv_m  [NI];
    // compares scheduled by due cycle (mod 16)
    bit          sv     [NI][16];
    bit          se     [NI][16];
    int unsigned si     [NI][16];
    bit [2:0]    svec   [NI][16];
    // behavioural DUV output history, already corrupted where requested
    bit          hist   [NI][16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_edge();
        int unsigned s;
        int unsigned w;
        bit          dprev;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            hist[k][cyc % 16] = (sel ? in1 : in0) ^ cor[k];
            if (!nreset) begin
                run_m[k]  = 1'b0;
                dn_m[k]   = 1'b0;
                err_m[k]  = 1'b0;
                acc_m[k]  = 0;
                pass_m[k] = 0;
                fail_m[k] = 0;
                ffi_m[k]  = 0;
                ffv_m[k]  = 3'd0;
                for (int j = 0; j < 16; j++) sv[k][j] = 1'b0;
            end else begin
                dprev   = dn_m[k];
                dn_m[k] = 1'b0;
                s = cyc % 16;
                if (sv[k][s]) begin
                    sv[k][s] = 1'b0;
                    if (out_w[k] == se[k][s]) begin
                        if (pass_m[k] < max_k[k]) pass_m[k]++;
                    end else begin
                        if (fail_m[k] < max_k[k]) fail_m[k]++;
                        if (!err_m[k]) begin
                            ffi_m[k] = si[k][s];
                            ffv_m[k] = svec[k][s];
                        end
                        err_m[k] = 1'b1;
                    end
                end
                if (!run_m[k] && !dprev && start) begin
                    run_m[k]  = 1'b1;
                    acc_m[k]  = 0;
                    pass_m[k] = 0;
                    fail_m[k] = 0;
                    err_m[k]  = 1'b0;
                    ffi_m[k]  = 0;
                    ffv_m[k]  = 3'd0;
                    for (int j = 0; j < 16; j++) sv[k][j] = 1'b0;
                end else if (run_m[k] && acc_m[k] < nvec_k[k] && vld) begin
                    w = (cyc + lat_k[k]) % 16;
                    sv[k][w]   = 1'b1;
                    se[k][w]   = sel ? in1 : in0;
                    si[k][w]   = acc_m[k];
                    svec[k][w] = {sel, in0, in1};
                    acc_m[k]++;
                    if (acc_m[k] == nvec_k[k]) last_m[k] = cyc;
                end
                if (run_m[k] && acc_m[k] == nvec_k[k] && cyc == last_m[k] + lat_k[k]) begin
                    run_m[k] = 1'b0;
                    dn_m[k]  = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_out();
        for (int k = 0; k < NI; k++) begin
            if (cyc + 1 >= lat_k[k]) out_w[k] = hist[k][(cyc + 1 - lat_k[k]) % 16];
            else                     out_w[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("busy%0d", k), busy_w[k], run_m[k]);
            check($sformatf("done%0d", k), done_w[k], dn_m[k]);
            check($sformatf("pass%0d", k), pass_w[k], pass_m[k]);
            check($sformatf("fail%0d", k), fail_w[k], fail_m[k]);
            check($sformatf("err%0d",  k), err_w[k],  err_m[k]);
`ifdef DUV_CHK_FIRST_FAIL_EN
            check($sformatf("ffidx%0d", k), ffi_w[k], ffi_m[k]);
            check($sformatf("ffvec%0d", k), ffv_w[k], ffv_m[k]);
`else
            check($sformatf("ffidx%0d", k), ffi_w[k], 0);
            check($sformatf("ffvec%0d", k), ffv_w[k], 0);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        drive_out();
    endtask

    task automatic set_vec(input int i);
        logic [2:0] b;
        b   = 3'(i);
        sel = b[2];
        in0 = b[1];
        in1 = b[0];
    endtask

    task automatic wait_done(input int k, input int budget, output int n);
        n = 0;
        while (!done_w[k] && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("done_seen%0d", k), done_w[k], 1);
    endtask

    initial begin
        int n;
        int pulses;
        for (int k = 0; k < NI; k++) begin
            cor[k]   = 1'b0;
            out_w[k] = 1'b0;
        end

        nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        repeat (2) tick();

        // all-pass on u_a; u_c sees every response inverted
        start = 1'b1; tick(); start = 1'b0;
        check("p1_busy", busy_w[0], 1);
        cor[2] = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_vec(i);
            tick();
        end
        vld = 1'b0;
        cor[2] = 1'b0;
        wait_done(0, 20, n);
        check("p1_done_lat", n, 1);
        check("p1_pass", pass_w[0], 8);
        check("p1_fail", fail_w[0], 0);
        check("p1_err", err_w[0], 0);
        repeat (6) tick();
        check("sat_fail", fail_w[2], 3);
        check("sat_err", err_w[2], 1);

        // garbage vectors while idle
        vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_vec(int'($urandom_range(0, 7)));
            cor[2] = 1'b1;
            tick();
        end
        vld = 1'b0;
        cor[2] = 1'b0;
        check("idle_pass", pass_w[0], 8);
        check("idle_sat", fail_w[2], 3);

        // forced failure on vector 5
        start = 1'b1; tick(); start = 1'b0;
        vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_vec(i);
            cor[0] = (i == 5);
            tick();
        end
        vld = 1'b0;
        cor[0] = 1'b0;
        wait_done(0, 20, n);
        check("ff_pass", pass_w[0], 7);
        check("ff_fail", fail_w[0], 1);
        check("ff_err", err_w[0], 1);
`ifdef DUV_CHK_FIRST_FAIL_EN
        check("ff_idx", ffi_w[0], 5);
        check("ff_vec", ffv_w[0], 3'b101);
`endif
        repeat (6) tick();

        // bubbles with LAT=3 on u_b
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 15; j++) begin
            vld = (j % 2 == 0);
            sel = 1'($urandom);
            in0 = 1'($urandom);
            in1 = 1'($urandom);
            tick();
        end
        vld = 1'b0;
        wait_done(1, 20, n);
        check("bub_done_lat", n, 3);
        check("bub_cmps", pass_w[1] + fail_w[1], 8);
        check("bub_pass", pass_w[1], 8);
        repeat (4) tick();

        // start mid-run and vld during drain are ignored
        start = 1'b1; tick(); start = 1'b0;
        pulses = 0;
        vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_vec(i);
            start = (i == 3);
            tick();
            if (done_w[0]) pulses++;
        end
        start = 1'b0;
        n = 0;
        while (!done_w[0] && n < 20) begin
            set_vec(int'($urandom_range(0, 7)));
            tick();
            n++;
            if (done_w[0]) pulses++;
        end
        check("ign_done_seen", done_w[0], 1);
        check("ign_pass", pass_w[0], 8);
        vld = 1'b0;
        start = 1'b1; tick();
        if (done_w[0]) pulses++;
        check("start_in_done", busy_w[0], 0);
        check("ign_pulses", pulses, 1);
        tick();
        check("start_after_done", busy_w[0], 1);
        start = 1'b0;

        // reset abort after vector 4
        vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_vec(i + 2);
            tick();
        end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        vld = 1'b0;
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_pass", pass_w[0], 0);
        check("rst_fail", fail_w[0], 0);
        check("rst_err", err_w[0], 0);
        check("rst_ffidx", ffi_w[0], 0);
        check("rst_ffvec", ffv_w[0], 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_w[0]) pulses++;
        end
        check("rst_no_done", pulses, 0);

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            nreset = ($urandom_range(0, 299) != 0);
            start  = ($urandom_range(0, 11) == 0);
            vld    = ($urandom_range(0, 3) != 0);
            sel    = 1'($urandom);
            in0    = 1'($urandom);
            in1    = 1'($urandom);
            for (int k = 0; k < NI; k++) cor[k] = ($urandom_range(0, 7) == 0);
            tick();
        end
        nreset = 1'b1;
        start  = 1'b0;
        vld    = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
